mcycle_unit: RTL and testbench



---
 rtl/mcycle_unit.sv | 155 +++++++++++++++
 tb/tb_mcycle_unit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mcycle_unit.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide on
// operand magnitudes, one bit per cycle, with a sign fix-up on the way to DONE.
module mcycle_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [1:0]       MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy,
  output logic             Done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  logic [1:0]         state_reg;
  logic [CW-1:0]      cnt_reg;
  logic               div_reg;
  logic               s1_reg;
  logic               s2_reg;
  logic               dz_reg;
  logic               busy_reg;
  logic               done_reg;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   rem_reg;
  logic [WIDTH-1:0]   op1_reg;
  logic [WIDTH-1:0]   res1_reg;
  logic [WIDTH-1:0]   res2_reg;
  logic [2*WIDTH-1:0] acc_reg;

  logic               in_sign1;
  logic               in_sign2;
  logic [WIDTH-1:0]   in_mag1;
  logic [WIDTH-1:0]   in_mag2;
  logic               accept;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic               div_ok;
  logic [WIDTH-1:0]   div_rem_next;
  logic [WIDTH-1:0]   div_q_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   res1_next;
  logic [WIDTH-1:0]   res2_next;

  always_comb begin
    in_sign1 = MCycleOp[0] & Operand1[WIDTH-1];
    in_sign2 = MCycleOp[0] & Operand2[WIDTH-1];
    in_mag1  = in_sign1 ? -Operand1 : Operand1;
    in_mag2  = in_sign2 ? -Operand2 : Operand2;
    accept   = Start && (state_reg != S_RUN);

    // Multiply: acc = {partial product, remaining multiplier bits}
    mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, a_reg};
    mul_next = acc_reg[0] ? {mul_sum, acc_reg[WIDTH-1:1]}
                          : {1'b0, acc_reg[2*WIDTH-1:1]};

    // Divide: dividend bits shift out of acc low half as quotient bits shift in
    div_shift    = {rem_reg, acc_reg[WIDTH-1]};
    div_ok       = div_shift >= {1'b0, a_reg};
    div_rem_next = div_ok ? WIDTH'(div_shift - {1'b0, a_reg}) : div_shift[WIDTH-1:0];
    div_q_next   = {acc_reg[WIDTH-2:0], div_ok};

    // Sign flags are only ever set for signed ops
    prod_fix = (s1_reg ^ s2_reg) ? -acc_reg : acc_reg;
    quot_fix = (s1_reg ^ s2_reg) ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
    rem_fix  = s1_reg ? -rem_reg : rem_reg;

    if (!div_reg) begin
      res1_next = prod_fix[WIDTH-1:0];
      res2_next = prod_fix[2*WIDTH-1:WIDTH];
    end else if (dz_reg) begin
      res1_next = '1;
      res2_next = op1_reg;
    end else begin
      res1_next = quot_fix;
      res2_next = rem_fix;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      div_reg   <= 1'b0;
      s1_reg    <= 1'b0;
      s2_reg    <= 1'b0;
      dz_reg    <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      a_reg     <= '0;
      rem_reg   <= '0;
      op1_reg   <= '0;
      acc_reg   <= '0;
      res1_reg  <= '0;
      res2_reg  <= '0;
    end else begin
      case (state_reg)
        S_RUN: begin
          if (cnt_reg == LAST) begin
            res1_reg  <= res1_next;
            res2_reg  <= res2_next;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= S_DONE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
            if (div_reg) begin
              acc_reg <= {acc_reg[2*WIDTH-1:WIDTH], div_q_next};
              rem_reg <= div_rem_next;
            end else begin
              acc_reg <= mul_next;
            end
          end
        end
        default: begin
          done_reg <= 1'b0;
          if (accept) begin
            div_reg   <= MCycleOp[1];
            s1_reg    <= in_sign1;
            s2_reg    <= in_sign2;
            dz_reg    <= MCycleOp[1] && (Operand2 == '0);
            op1_reg   <= Operand1;
            a_reg     <= MCycleOp[1] ? in_mag2 : in_mag1;
            acc_reg   <= {{WIDTH{1'b0}}, (MCycleOp[1] ? in_mag1 : in_mag2)};
            rem_reg   <= '0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= S_RUN;
          end else begin
            busy_reg  <= 1'b0;
            state_reg <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign Result1 = res1_reg;
  assign Result2 = res2_reg;
  assign Busy    = busy_reg;
  assign Done    = done_reg;

endmodule

// File: tb/tb_mcycle_unit.sv
// Bench for mcycle_unit: WIDTH=32 and WIDTH=8 instances, an arithmetic reference
// model checked every cycle, and directed operations with literal expectations.
module tb_mcycle_unit;

  logic        clk;
  logic        reset32, start32, busy32, done32;
  logic [1:0]  op32;
  logic [31:0] a32, b32, r1_32, r2_32;
  logic        reset8, start8, busy8, done8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8, r1_8, r2_8;

  int checks = 0;
  int failures = 0;

  mcycle_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset32), .Start(start32), .MCycleOp(op32),
    .Operand1(a32), .Operand2(b32), .Result1(r1_32), .Result2(r2_32),
    .Busy(busy32), .Done(done32)
  );

  mcycle_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset8), .Start(start8), .MCycleOp(op8),
    .Operand1(a8), .Operand2(b8), .Result1(r1_8), .Result2(r2_8),
    .Busy(busy8), .Done(done8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Reference arithmetic on w-bit operands using 64-bit integers
  function automatic void calc(input int w, input logic [1:0] op, input longint a, input longint b,
                               output longint r1, output longint r2);
    longint mask, sa, sb, p;
    mask = (longint'(1) <<< w) - 1;
    sa = (op[0] && a[w-1]) ? a - (longint'(1) <<< w) : a;
    sb = (op[0] && b[w-1]) ? b - (longint'(1) <<< w) : b;
    if (!op[1]) begin
      p  = sa * sb;
      r1 = p & mask;
      r2 = (p >> w) & mask;
    end else if (b == 0) begin
      r1 = mask;
      r2 = a;
    end else if (op[0]) begin
      r1 = (sa / sb) & mask;
      r2 = (sa % sb) & mask;
    end else begin
      r1 = a / b;
      r2 = a % b;
    end
  endfunction

  // Model: a request accepted while idle completes WIDTH+1 edges later
  bit     m_busy[2], m_done[2];
  int     m_left[2];
  longint m_r1[2], m_r2[2], m_p1[2], m_p2[2];

  task automatic model_step(input int i, input int w, input logic rst, input logic st,
                            input logic [1:0] op, input longint a, input longint b);
    longint p1, p2;
    if (rst) begin
      m_busy[i] = 0; m_done[i] = 0; m_left[i] = 0; m_r1[i] = 0; m_r2[i] = 0;
    end else if (st && !m_busy[i]) begin
      calc(w, op, a, b, p1, p2);
      m_p1[i] = p1; m_p2[i] = p2;
      m_busy[i] = 1; m_done[i] = 0; m_left[i] = w + 1;
    end else if (m_busy[i]) begin
      m_left[i]--;
      m_done[i] = 0;
      if (m_left[i] == 0) begin
        m_busy[i] = 0; m_done[i] = 1; m_r1[i] = m_p1[i]; m_r2[i] = m_p2[i];
      end
    end else begin
      m_done[i] = 0;
    end
  endtask

  always @(posedge clk) begin
    model_step(0, 32, reset32, start32, op32, longint'(a32), longint'(b32));
    model_step(1, 8, reset8, start8, op8, longint'(a8), longint'(b8));
  end

  always @(negedge clk) begin
    check("cyc32.Busy", 64'(busy32), 64'(m_busy[0]));
    check("cyc32.Done", 64'(done32), 64'(m_done[0]));
    check("cyc32.Result1", 64'(r1_32), m_r1[0]);
    check("cyc32.Result2", 64'(r2_32), m_r2[0]);
    check("cyc8.Busy", 64'(busy8), 64'(m_busy[1]));
    check("cyc8.Done", 64'(done8), 64'(m_done[1]));
    check("cyc8.Result1", 64'(r1_8), m_r1[1]);
    check("cyc8.Result2", 64'(r2_8), m_r2[1]);
  end

  // Called at a falling edge; poke >= 0 pulses Start with junk that many cycles in
  task automatic run32(input string nm, input int gap, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] e1, input logic [31:0] e2, input int poke);
    int k, nb;
    repeat (gap) @(negedge clk);
    start32 = 1'b1; op32 = op; a32 = a; b32 = b;
    @(posedge clk);
    @(negedge clk);
    start32 = 1'b0; op32 = 2'($urandom); a32 = $urandom; b32 = $urandom;
    k = 0; nb = 0;
    while (!done32 && k < 100) begin
      if (busy32) nb++;
      @(negedge clk);
      k++;
      start32 = (k == poke);
      if (k == poke) begin
        op32 = 2'($urandom); a32 = $urandom; b32 = $urandom;
      end
    end
    check({nm, ".latency"}, 64'(k), 64'd33);
    check({nm, ".busy_cycles"}, 64'(nb), 64'd33);
    check({nm, ".Result1"}, 64'(r1_32), 64'(e1));
    check({nm, ".Result2"}, 64'(r2_32), 64'(e2));
  endtask

  task automatic run8(input string nm, input logic [1:0] op, input logic [7:0] a,
                      input logic [7:0] b, input logic [7:0] e1, input logic [7:0] e2);
    int k;
    repeat (2) @(negedge clk);
    start8 = 1'b1; op8 = op; a8 = a; b8 = b;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    k = 0;
    while (!done8 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check({nm, ".latency"}, 64'(k), 64'd9);
    check({nm, ".Result1"}, 64'(r1_8), 64'(e1));
    check({nm, ".Result2"}, 64'(r2_8), 64'(e2));
  endtask

  initial begin
    int nd;
    reset32 = 1'b1; start32 = 1'b0; op32 = 2'b00; a32 = '0; b32 = '0;
    reset8  = 1'b1; start8  = 1'b0; op8  = 2'b00; a8  = '0; b8  = '0;
    repeat (3) @(negedge clk);
    check("reset.Busy", 64'(busy32), 64'd0);
    check("reset.Done", 64'(done32), 64'd0);
    check("reset.Result1", 64'(r1_32), 64'd0);
    check("reset.Result2", 64'(r2_32), 64'd0);
    reset32 = 1'b0; reset8 = 1'b0;

    run32("umul_max",   2, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, -1);
    run32("smul_m3x7",  2, 2'b01, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFEB, 32'hFFFFFFFF, -1);
    run32("smul_min2",  2, 2'b01, 32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000, -1);
    run32("udiv_100_7", 2, 2'b10, 32'd100,      32'd7,        32'd14,       32'd2,        -1);
    run32("sdiv_m7_2",  2, 2'b11, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, -1);
    run32("sdiv_7_m2",  2, 2'b11, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        -1);
    run32("udiv_5_0",   2, 2'b10, 32'd5,        32'd0,        32'hFFFFFFFF, 32'd5,        -1);
    run32("sdiv_m5_0",  2, 2'b11, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFB, -1);
    run32("sdiv_ovf",   2, 2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        -1);
    run32("ignored_start", 2, 2'b00, 32'd1234, 32'd5678, 32'h006AE9BC, 32'd0, 10);
    run32("b2b_first",  2, 2'b10, 32'd1000,     32'd10,       32'd100,      32'd0,        -1);
    run32("b2b_second", 0, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        32'd0,        -1);

    // Reset mid-operation: outputs clear and no Done pulse follows
    repeat (2) @(negedge clk);
    start32 = 1'b1; op32 = 2'b00; a32 = 32'd7; b32 = 32'd9;
    @(posedge clk);
    @(negedge clk);
    start32 = 1'b0;
    repeat (15) @(negedge clk);
    reset32 = 1'b1;
    @(negedge clk);
    reset32 = 1'b0;
    check("midrst.Busy", 64'(busy32), 64'd0);
    check("midrst.Done", 64'(done32), 64'd0);
    check("midrst.Result1", 64'(r1_32), 64'd0);
    check("midrst.Result2", 64'(r2_32), 64'd0);
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (done32) nd++;
    end
    check("midrst.no_done", 64'(nd), 64'd0);

    run8("w8_umul_ff", 2'b00, 8'hFF, 8'hFF, 8'h01, 8'hFE);
    run8("w8_sdiv_ovf", 2'b11, 8'h80, 8'hFF, 8'h80, 8'h00);
    run8("w8_sdiv_m7_2", 2'b11, 8'hF9, 8'h02, 8'hFD, 8'hFF);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
